// File: rtl/csa_resolve_adder.sv
// csa_resolve_adder: word-serial carry-select resolver turning a sum/carry pair into binary, 2-stage valid/ready pipeline
module csa_resolve_adder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] sum_in,
    input  logic [DATA_WIDTH-1:0] cout_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_carry
);
    localparam int H = DATA_WIDTH / 2;

    logic         s1_valid, s1_first, s1_last, s1_c_lo, s1_hc0, s1_hc1, carry_q;
    logic [H-1:0] s1_lo, s1_hi0, s1_hi1;
    logic         cin, in_xfer, s2_load;
    logic [H:0]   lo_sum, hi_sum0, hi_sum1;

    assign cin     = in_first ? 1'b0 : carry_q;
    assign lo_sum  = {1'b0, sum_in[H-1:0]} + {1'b0, cout_in[H-1:0]} + {{H{1'b0}}, cin};
    assign hi_sum0 = {1'b0, sum_in[DATA_WIDTH-1:H]} + {1'b0, cout_in[DATA_WIDTH-1:H]};
    assign hi_sum1 = hi_sum0 + {{H{1'b0}}, 1'b1};
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_xfer  = in_valid && in_ready;

    // carry_q resolves in stage 1 so consecutive words of one operand chain without a bubble
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_c_lo  <= 1'b0;
            s1_hc0   <= 1'b0;
            s1_hc1   <= 1'b0;
            s1_lo    <= '0;
            s1_hi0   <= '0;
            s1_hi1   <= '0;
            carry_q  <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_c_lo  <= lo_sum[H];
            s1_lo    <= lo_sum[H-1:0];
            s1_hi0   <= hi_sum0[H-1:0];
            s1_hc0   <= hi_sum0[H];
            s1_hi1   <= hi_sum1[H-1:0];
            s1_hc1   <= hi_sum1[H];
            carry_q  <= lo_sum[H] ? hi_sum1[H] : hi_sum0[H];
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_first <= s1_first;
            out_last  <= s1_last;
            out_data  <= {s1_c_lo ? s1_hi1 : s1_hi0, s1_lo};
            out_carry <= s1_c_lo ? s1_hc1 : s1_hc0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_csa_resolve_adder.sv
// tb_csa_resolve_adder: scoreboard bench for the sum/carry resolver pipeline
module tb_csa_resolve_adder;
    localparam int W = 32;

    typedef struct packed {
        logic         f;
        logic         l;
        logic         c;
        logic [W-1:0] d;
    } exp_t;

    logic         clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [W-1:0] sum_in = '0, cout_in = '0;
    logic         in_ready, out_valid, out_first, out_last, out_carry;
    logic [W-1:0] out_data, held;
    logic         tb_carry = 1'b0;
    int           n_cmp = 0, n_err = 0, run = 0, max_run = 0;
    exp_t         sb[$];
    exp_t         e;

    csa_resolve_adder #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .sum_in(sum_in), .cout_in(cout_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
        .out_last(out_last), .out_data(out_data), .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic f, input logic l, input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W:0] r;
        bit done = 0;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        sum_in   = s;
        cout_in  = c;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                r = {1'b0, s} + {1'b0, c} + {{W{1'b0}}, (f ? 1'b0 : tb_carry)};
                tb_carry = r[W];
                sb.push_back('{f, l, r[W], r[W-1:0]});
                done = 1;
            end
            tick();
        end
        if (!done) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            run = 0;
        end else begin
            run = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("data", out_data, e.d);
                    chk("carry", out_carry, e.c);
                    chk("first", out_first, e.f);
                    chk("last", out_last, e.l);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_carry", out_carry, 0);
        rstn = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);

        push(1, 1, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("lat_n1_valid", out_valid, 0);
        tick();
        chk("lat_n2_valid", out_valid, 1);
        chk("single_data", out_data, 32'h0);
        chk("single_carry", out_carry, 1);
        repeat (3) tick();

        push(1, 1, 32'h0001_FFFF, 32'h0000_0001);
        tick();
        chk("csel_data", out_data, 32'h0002_0000);
        push(1, 1, 32'h1234_0000, 32'h0000_5678);
        tick();
        chk("nocarry_data", out_data, 32'h1234_5678);
        repeat (3) tick();

        max_run = 0;
        push(1, 0, 32'hFFFF_FFFF, 32'h1);
        push(0, 0, 32'hFFFF_FFFF, 32'h0);
        push(0, 1, 32'h0, 32'h0);
        tick();
        chk("chain_last_data", out_data, 32'h1);
        repeat (4) tick();
        chk("chain_run", max_run, 3);

        fork
            begin
                push(1, 0, $urandom, $urandom);
                push(0, 0, $urandom, $urandom);
                push(0, 0, $urandom, $urandom);
                push(0, 1, $urandom, $urandom);
            end
            begin
                for (int i = 0; i < 20 && !out_valid; i++) tick();
                chk("bp_valid_rise", out_valid, 1);
                out_ready = 1'b0;
                held = out_data;
                repeat (5) begin
                    tick();
                    chk("bp_hold", out_data, held);
                end
                chk("bp_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        repeat (6) tick();
        chk("bp_drained", sb.size(), 0);

        push(1, 1, 32'hFFFF_FFFF, 32'h1);
        push(1, 1, 32'h5, 32'h3);
        tick();
        chk("first_clears_carry", out_data, 32'h8);
        repeat (3) tick();

        push(1, 0, 32'd10, 32'd20);
        push(0, 1, 32'd7, 32'd8);
        rstn = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        sb.delete();
        tb_carry = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        push(1, 1, 32'd2, 32'd3);
        tick();
        chk("postrst_data", out_data, 32'd5);
        chk("postrst_carry", out_carry, 0);
        repeat (4) tick();
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
